// File: rtl/exwb_skid_buffer_if.sv
// EX->WB handshake bundle for exwb_skid_buffer: EX-side entry, WB-side head entry,
// flush, and the forwarding query/response lines.
interface exwb_skid_buffer_if #(
   parameter int DATA_W = 33,
   parameter int RD_W   = 6
);
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic              in_ctrl_regwrt;
   logic              in_ctrl_branch;
   logic              in_ctrl_btype;
   logic              in_ctrl_jump;
   logic              in_ctrl_memtoreg;
   logic              in_ctrl_neg;
   logic              in_ctrl_zero;
   logic [DATA_W-1:0] in_memdata;
   logic [DATA_W-1:0] in_aluresult;
   logic [RD_W-1:0]   in_rd;
   logic              out_valid;
   logic              out_ready;
   logic              out_ctrl_regwrt;
   logic              out_ctrl_branch;
   logic              out_ctrl_btype;
   logic              out_ctrl_jump;
   logic              out_ctrl_memtoreg;
   logic              out_ctrl_neg;
   logic              out_ctrl_zero;
   logic [DATA_W-1:0] out_memdata;
   logic [DATA_W-1:0] out_aluresult;
   logic [RD_W-1:0]   out_rd;
   logic [DATA_W-1:0] out_wbdata;
   logic              out_pcsel;
   logic [RD_W-1:0]   fwd_rs;
   logic [RD_W-1:0]   fwd_rt;
   logic              fwd_rs_hit;
   logic              fwd_rt_hit;
   logic [DATA_W-1:0] fwd_data;

   modport slave (
      input  flush, in_valid, in_ctrl_regwrt, in_ctrl_branch, in_ctrl_btype, in_ctrl_jump,
             in_ctrl_memtoreg, in_ctrl_neg, in_ctrl_zero, in_memdata, in_aluresult, in_rd,
             out_ready, fwd_rs, fwd_rt,
      output in_ready, out_valid, out_ctrl_regwrt, out_ctrl_branch, out_ctrl_btype,
             out_ctrl_jump, out_ctrl_memtoreg, out_ctrl_neg, out_ctrl_zero, out_memdata,
             out_aluresult, out_rd, out_wbdata, out_pcsel, fwd_rs_hit, fwd_rt_hit, fwd_data
   );

   modport master (
      output flush, in_valid, in_ctrl_regwrt, in_ctrl_branch, in_ctrl_btype, in_ctrl_jump,
             in_ctrl_memtoreg, in_ctrl_neg, in_ctrl_zero, in_memdata, in_aluresult, in_rd,
             out_ready, fwd_rs, fwd_rt,
      input  in_ready, out_valid, out_ctrl_regwrt, out_ctrl_branch, out_ctrl_btype,
             out_ctrl_jump, out_ctrl_memtoreg, out_ctrl_neg, out_ctrl_zero, out_memdata,
             out_aluresult, out_rd, out_wbdata, out_pcsel, fwd_rs_hit, fwd_rt_hit, fwd_data
   );
endinterface

// File: rtl/exwb_skid_buffer.sv
// Two-entry EX->WB skid buffer (head + skid) with PC-select and WB forwarding.
// Define EXWB_FWD_EN to enable the forwarding comparators; otherwise the fwd outputs tie to 0.
module exwb_skid_buffer #(
   parameter int DATA_W = 33,
   parameter int RD_W   = 6
) (
   input  logic                clk,
   input  logic                rst,
   exwb_skid_buffer_if.slave   bus
);

   typedef struct packed {
      logic              regwrt;
      logic              branch;
      logic              btype;
      logic              jump;
      logic              memtoreg;
      logic              neg;
      logic              zero;
      logic [DATA_W-1:0] memdata;
      logic [DATA_W-1:0] aluresult;
      logic [RD_W-1:0]   rd;
   } entry_t;

   entry_t in_entry;
   entry_t head_p0;
   entry_t skid_p1;
   logic   vld_p0;
   logic   vld_p1;
   logic   accept;
   logic   pop;
   logic   to_skid;

   assign in_entry = '{regwrt: bus.in_ctrl_regwrt, branch: bus.in_ctrl_branch,
                       btype: bus.in_ctrl_btype, jump: bus.in_ctrl_jump,
                       memtoreg: bus.in_ctrl_memtoreg, neg: bus.in_ctrl_neg,
                       zero: bus.in_ctrl_zero, memdata: bus.in_memdata,
                       aluresult: bus.in_aluresult, rd: bus.in_rd};

   assign accept  = bus.in_valid & bus.in_ready;
   assign pop     = vld_p0 & bus.out_ready;
   assign to_skid = accept & vld_p0 & ~pop;

   // Head stage: reset clears data too so out_* read 0 while in reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p0  <= 1'b0;
         vld_p1  <= 1'b0;
         head_p0 <= '0;
      end else if (bus.flush) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
      end else begin
         if (pop && vld_p1) begin
            head_p0 <= skid_p1;
            vld_p1  <= 1'b0;
         end else if (accept && (!vld_p0 || pop)) begin
            head_p0 <= in_entry;
            vld_p0  <= 1'b1;
         end else if (pop) begin
            vld_p0 <= 1'b0;
         end
         if (to_skid)
            vld_p1 <= 1'b1;
      end
   end

   // Skid stage: data only, occupancy is tracked by vld_p1
   always_ff @(posedge clk) begin
      if (to_skid)
         skid_p1 <= in_entry;
   end

   assign bus.in_ready          = ~vld_p1;
   assign bus.out_valid         = vld_p0;
   assign bus.out_ctrl_regwrt   = head_p0.regwrt;
   assign bus.out_ctrl_branch   = head_p0.branch;
   assign bus.out_ctrl_btype    = head_p0.btype;
   assign bus.out_ctrl_jump     = head_p0.jump;
   assign bus.out_ctrl_memtoreg = head_p0.memtoreg;
   assign bus.out_ctrl_neg      = head_p0.neg;
   assign bus.out_ctrl_zero     = head_p0.zero;
   assign bus.out_memdata       = head_p0.memdata;
   assign bus.out_aluresult     = head_p0.aluresult;
   assign bus.out_rd            = head_p0.rd;
   assign bus.out_wbdata        = head_p0.memtoreg ? head_p0.memdata : head_p0.aluresult;
   assign bus.out_pcsel         = vld_p0 & (head_p0.jump |
                                  (head_p0.branch & (head_p0.btype ? head_p0.neg : head_p0.zero)));

`ifdef EXWB_FWD_EN
   logic rd_live;
   assign rd_live        = vld_p0 & head_p0.regwrt & (head_p0.rd != '0);
   assign bus.fwd_rs_hit = rd_live & (head_p0.rd == bus.fwd_rs);
   assign bus.fwd_rt_hit = rd_live & (head_p0.rd == bus.fwd_rt);
   assign bus.fwd_data   = bus.out_wbdata;
`else
   logic unused_fwd;
   assign unused_fwd     = ^{bus.fwd_rs, bus.fwd_rt};
   assign bus.fwd_rs_hit = 1'b0;
   assign bus.fwd_rt_hit = 1'b0;
   assign bus.fwd_data   = '0;
`endif

endmodule
